// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared AHB encodings, FSM states, bank count and byte-strobe helper for sram_ahb_ctrl
package sram_ctrl_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam int NUM_BANKS = 4;
  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_WR_HOLD, ST_ERR1, ST_ERR2} state_t;
  // active-low byte write enables for a transfer of the given size at byte offset a
  function automatic logic [3:0] byte_strb(input logic [2:0] size, input logic [1:0] a);
    return size == 3'd0 ? ~(4'b0001 << a) : size == 3'd1 ? (a[1] ? 4'b0011 : 4'b1100) : 4'b0000;
  endfunction
endpackage

// File: rtl/sram_ahb_decode.sv
// sram_ahb_decode: bank decode, legality check and byte-strobe generation for one AHB address phase
//   i_bank_sel  bank index taken from the address
//   i_lo        haddr[1:0]
//   i_hsize     AHB size
//   i_bank_on   per-bank power-good
//   o_bank      one-hot (active-high) selected bank
//   o_illegal   size/alignment violation or powered-down bank
//   o_strb      active-low byte write enables
module sram_ahb_decode
  import sram_ctrl_pkg::*;
(
  input  logic [1:0]           i_bank_sel,
  input  logic [1:0]           i_lo,
  input  logic [2:0]           i_hsize,
  input  logic [NUM_BANKS-1:0] i_bank_on,
  output logic [NUM_BANKS-1:0] o_bank,
  output logic                 o_illegal,
  output logic [3:0]           o_strb
);
  assign o_bank = NUM_BANKS'(1) << i_bank_sel;
  assign o_illegal = (i_hsize > 3'd2) | ((i_hsize == 3'd1) & i_lo[0]) |
                     ((i_hsize == 3'd2) & (|i_lo)) | ~(|(o_bank & i_bank_on));
  assign o_strb = byte_strb(i_hsize, i_lo);
endmodule

// File: rtl/sram_ahb_ctrl.sv
// sram_ahb_ctrl: AHB-Lite slave front end driving the SRAM island bank enables, strobes and address
//   hclk/hreset            clock, synchronous active-high reset
//   hsel/hready_in/htrans/hwrite/hsize/haddr  AHB address phase
//   bank_on                per-bank power-good
//   hreadyout/hresp        AHB response
//   addr/wen_g/cen0..3     SRAM access (same cycle as the access)
//   reg_cen0..3            registered read bank select for the read data phase
//   g_wr_dphase            high while the SRAM performs a write
module sram_ahb_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BANK_LSB = 13,
  parameter int ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic              hready_in,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [3:0]        bank_on,
  output logic              hreadyout,
  output logic              hresp,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        wen_g,
  output logic              cen0,
  output logic              cen1,
  output logic              cen2,
  output logic              cen3,
  output logic              reg_cen0,
  output logic              reg_cen1,
  output logic              reg_cen2,
  output logic              reg_cen3,
  output logic              g_wr_dphase
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_waddr;
  logic [NUM_BANKS-1:0] r_wbank, r_reg_cen, w_bank, w_cen;
  logic [3:0] r_wstrb, w_strb;
  logic w_illegal, w_rd_pres, w_stall, w_sample, w_rd_go, w_wr_cap, w_wr_act, w_err1;
  sram_ahb_decode u_dec (
    .i_bank_sel(haddr[BANK_LSB+1:BANK_LSB]),
    .i_lo      (haddr[1:0]),
    .i_hsize   (hsize),
    .i_bank_on (bank_on),
    .o_bank    (w_bank),
    .o_illegal (w_illegal),
    .o_strb    (w_strb)
  );
  assign w_err1 = ~hreset & (r_state == ST_ERR1);
  assign w_wr_act = ~hreset & (r_state == ST_WR);
  // a read arriving during the write data phase would collide on the single SRAM port
  assign w_rd_pres = hsel & htrans[1] & ~hwrite;
  assign w_stall = w_wr_act & w_rd_pres;
  assign w_sample = ~hreset & hsel & hready_in & htrans[1] & ~w_err1 & ~w_stall;
  assign w_rd_go = w_sample & ~w_illegal & ~hwrite;
  assign w_wr_cap = w_sample & ~w_illegal & hwrite;
  always_comb begin
    w_next = w_err1 ? ST_ERR2 : w_stall ? ST_WR_HOLD : (w_sample & w_illegal) ? ST_ERR1 : w_wr_cap ? ST_WR : ST_IDLE;
    w_cen = w_wr_act ? ~r_wbank : w_rd_go ? ~w_bank : '1;
    addr = w_wr_act ? r_waddr : w_rd_go ? haddr : '0;
    wen_g = w_wr_act ? r_wstrb : 4'hF;
    g_wr_dphase = w_wr_act;
    hreadyout = ~(w_stall | w_err1);
    hresp = ~hreset & ((r_state == ST_ERR1) | (r_state == ST_ERR2));
  end
  assign {cen3, cen2, cen1, cen0} = w_cen;
  assign {reg_cen3, reg_cen2, reg_cen1, reg_cen0} = r_reg_cen;
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= ST_IDLE;
      r_waddr <= '0;
      r_wbank <= '0;
      r_wstrb <= 4'hF;
      r_reg_cen <= '1;
    end else begin
      r_state <= w_next;
      r_reg_cen <= w_rd_go ? ~w_bank : '1;
      if (w_wr_cap) begin
        r_waddr <= haddr;
        r_wbank <= w_bank;
        r_wstrb <= w_strb;
      end
    end
  end
endmodule

// File: doc/sram_ahb_ctrl.md
Name: sram_ahb_ctrl

Overview:
- AHB-Lite slave front end that sits directly upstream of the SRAM voltage island.
- Converts AHB transfers into the island's bank enables, byte write enables, word address, read-data-phase bank selects and write-data-phase flag.
- Inserts one wait state when a read directly follows a write.
- Returns a two-cycle ERROR for accesses to powered-down banks and for illegal sizes.
- hwdata and hrdata_island bypass this block.

Parameters:
- BANK_LSB, 13, lowest address bit of the 2-bit bank select (4 banks x 2k words x 32 bits).
- ADDR_W, 32, haddr and addr width.

Ports:
- hclk  in  1  system clock
- hreset  in  1  synchronous, active-high reset
- hsel  in  1  slave select
- hready_in  in  1  bus ready (AHB data phase completes when high)
- htrans  in  2  AHB transfer type
- hwrite  in  1  1 = write
- hsize  in  3  AHB size
- haddr  in  ADDR_W  AHB address
- bank_on  in  4  per-bank power-good from the power controller
- hreadyout  out  1  slave ready
- hresp  out  1  1 = ERROR
- addr  out  ADDR_W  SRAM address; island uses addr[12:2]
- wen_g  out  4  active-low byte write enables, shared by all banks
- cen0..cen3  out  1 each  active-low bank enables, same cycle as SRAM access
- reg_cen0..reg_cen3  out  1 each  active-low, registered read bank select for the read data phase
- g_wr_dphase  out  1  high in the cycle the SRAM performs a write; blanks island read data

Behaviour:
- Valid transfer: hsel & hready_in & htrans[1].
- Bank index: haddr[BANK_LSB+1:BANK_LSB].
- Illegal access, any of:
  - hsize > 2;
  - hsize == 1 with haddr[0] == 1;
  - hsize == 2 with haddr[1:0] != 0;
  - bank_on[bank] == 0.
- Reset values: hreadyout 1, hresp 0, cen* 1, reg_cen* 1, wen_g 4'hF, g_wr_dphase 0, addr 0, state IDLE, pending-write registers cleared.
- While hreset is high, cen* are forced to 1 combinationally. An aborted write is never performed.
- FSM states: IDLE, WR, WR_HOLD, ERR1, ERR2.
- Read, legal, while state is IDLE or WR_HOLD:
  - Same cycle: cen[bank] = 0, addr = haddr, wen_g = F.
  - Next cycle: reg_cen[bank] = 0, all other reg_cen = 1, hreadyout = 1. Read data is therefore zero-wait.
  - reg_cen* return to 1 in any data phase that is not a read.
- Write, legal, address phase:
  - Register haddr, the bank and the byte strobes; next state is WR.
  - No cen is asserted in the address phase.
- State WR (write data phase):
  - cen[reg bank] = 0, addr = registered address, wen_g = registered strobes, g_wr_dphase = 1.
  - If no read is being presented (hsel & htrans[1] & ~hwrite): hreadyout = 1. A new legal write moves to WR, any other legal transfer is handled as in IDLE, no transfer goes to IDLE.
  - If a read is being presented: hreadyout = 0, next state WR_HOLD. The write is still performed this cycle.
- State WR_HOLD:
  - g_wr_dphase = 0, hreadyout = 1.
  - The held read address is now sampled and issued as a normal read.
- Back-to-back writes run zero-wait, with no port conflict.
- Byte strobes (active low):
  - hsize 0: bit haddr[1:0] = 0, others 1.
  - hsize 1: haddr[1] = 0 gives 4'b1100; haddr[1] = 1 gives 4'b0011.
  - hsize 2: 4'b0000.
- Illegal access:
  - No cen asserted and no state is captured.
  - ERR1: hreadyout 0, hresp 1.
  - ERR2: hreadyout 1, hresp 1.
  - Then handle as in IDLE. A transfer presented in ERR2 is sampled normally.
- IDLE/BUSY transfers and hsel = 0: OKAY, zero wait, no cen.
- bank_on is sampled only in the address phase. A bank powering down mid data phase does not abort the access.

Decomposition:
- sram_ctrl_pkg holds:
  - htrans encodings (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11);
  - the FSM state enum;
  - NUM_BANKS = 4;
  - the byte-strobe function.
- One sub-module, sram_ahb_decode: combinational bank decode, legality check and strobe generation.
- FSM and registers stay in the top.

Test Plan:
- Word write to 0x0000_2004, then read of the same address:
  - Write data phase: cen1 = 0, wen_g = 0000, g_wr_dphase = 1, addr = 0x2004.
  - Read is stalled one cycle (hreadyout = 0), then cen1 = 0 with wen_g = F.
  - Next cycle reg_cen1 = 0.
- Byte writes to 0x0000_0001 and 0x0000_0003 back-to-back: wen_g 1101 then 0111 on consecutive cycles, cen0 = 0, hreadyout never low.
- Halfword write at 0x0000_6002: wen_g = 0011, cen3 = 0. Halfword at 0x0000_6001: ERR1 then ERR2 response, no cen asserted.
- bank_on = 4'b1011, read 0x0000_4000: two-cycle ERROR, cen2 stays 1. Read 0x0000_0000 presented in ERR2: zero-wait OKAY, reg_cen0 = 0.
- hreset asserted in WR state: same cycle all cen = 1. After release all outputs are at reset values and no write occurs.
- Reads streamed across banks 0, 1, 2, 3: reg_cen rotates one-hot-low with one-cycle lag, hreadyout = 1 throughout.
